sc_speed_scheduler: RTL

Level-driven scroll-speed scheduler for the game datapath. Converts the current level number into one of three tick periods and emits a one-cycle load strobe at that rate, which paces the road/obstacle shift registers. It generalises the fixed level-to-speed mapping into a parametrised three-band scheduler with start, pause and clear control, plus band-change and load-count reporting. It sits between the level counter and the shift-register load/mux-select inputs.

---
 rtl/sc_speed_scheduler.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sc_speed_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : sc_speed_scheduler
// Purpose : Maps the current level to one of three tick periods and emits a
//           one-cycle load strobe at that rate (start/pause/clear control).
// Rev     : 1.0  initial release
// ============================================================================
module sc_speed_scheduler #(
  parameter int TIMER_WIDTH   = 25,
  parameter int LEVEL_WIDTH   = 8,
  parameter int LOADCNT_WIDTH = 8,
  parameter int PERIOD_0      = 17500000,
  parameter int PERIOD_1      = 15000000,
  parameter int PERIOD_2      = 12500000,
  parameter int THRESH_0      = 10,
  parameter int THRESH_1      = 32
) (
  input  logic                     SC_SPEEDSCHED_CLOCK_50,
  input  logic                     SC_SPEEDSCHED_RESET_InHigh,
  input  logic                     SC_SPEEDSCHED_START_InLow,
  input  logic                     SC_SPEEDSCHED_PAUSE_InLow,
  input  logic                     SC_SPEEDSCHED_CLEAR_InHigh,
  input  logic [LEVEL_WIDTH-1:0]   SC_SPEEDSCHED_LEVEL_In,
  output logic                     SC_SPEEDSCHED_LOAD_Out,
  output logic [1:0]               SC_SPEEDSCHED_BAND_Out,
  output logic                     SC_SPEEDSCHED_BANDCHG_Out,
  output logic [1:0]               SC_SPEEDSCHED_STATE_Out,
  output logic [LOADCNT_WIDTH-1:0] SC_SPEEDSCHED_LOADCOUNT_Out
);

  localparam logic [TIMER_WIDTH-1:0] c_PER0 = TIMER_WIDTH'(PERIOD_0);
  localparam logic [TIMER_WIDTH-1:0] c_PER1 = TIMER_WIDTH'(PERIOD_1);
  localparam logic [TIMER_WIDTH-1:0] c_PER2 = TIMER_WIDTH'(PERIOD_2);
  localparam logic [LEVEL_WIDTH:0]   c_TH0  = (LEVEL_WIDTH+1)'(THRESH_0);
  localparam logic [LEVEL_WIDTH:0]   c_TH1  = (LEVEL_WIDTH+1)'(THRESH_1);

  typedef enum logic [1:0] {
    c_IDLE  = 2'b00,
    c_RUN   = 2'b01,
    c_PAUSE = 2'b10
  } state_t;

  state_t                   r_state;
  logic [TIMER_WIDTH-1:0]   r_cnt;
  logic [TIMER_WIDTH-1:0]   r_period_lat;
  logic [1:0]               r_band_lat;
  logic                     r_load;
  logic                     r_bandchg;
  logic [LOADCNT_WIDTH-1:0] r_loadcnt;
  logic                     r_start_q;
  logic                     r_armed;

  logic [1:0]             w_band_sel;
  logic [TIMER_WIDTH-1:0] w_period_sel;
  logic                   w_start_edge;
  logic                   w_term;

  always_comb begin
    w_band_sel   = 2'd2;
    w_period_sel = c_PER2;
    if ({1'b0, SC_SPEEDSCHED_LEVEL_In} <= c_TH0) begin
      w_band_sel   = 2'd0;
      w_period_sel = c_PER0;
    end else if ({1'b0, SC_SPEEDSCHED_LEVEL_In} <= c_TH1) begin
      w_band_sel   = 2'd1;
      w_period_sel = c_PER1;
    end
  end

  // r_armed blocks a start that was already held low when reset released.
  assign w_start_edge = r_armed & r_start_q & ~SC_SPEEDSCHED_START_InLow;
  assign w_term       = (r_cnt == (r_period_lat - TIMER_WIDTH'(1)));

  always_ff @(posedge SC_SPEEDSCHED_CLOCK_50 or posedge SC_SPEEDSCHED_RESET_InHigh) begin
    if (SC_SPEEDSCHED_RESET_InHigh) begin
      r_state      <= c_IDLE;
      r_cnt        <= '0;
      r_period_lat <= c_PER0;
      r_band_lat   <= 2'd0;
      r_load       <= 1'b0;
      r_bandchg    <= 1'b0;
      r_loadcnt    <= '0;
      r_start_q    <= 1'b1;
      r_armed      <= 1'b0;
    end else begin
      r_start_q <= SC_SPEEDSCHED_START_InLow;
      if (SC_SPEEDSCHED_START_InLow) r_armed <= 1'b1;
      r_load    <= 1'b0;
      r_bandchg <= 1'b0;
      if (SC_SPEEDSCHED_CLEAR_InHigh) begin
        r_state   <= c_IDLE;
        r_cnt     <= '0;
        r_loadcnt <= '0;
      end else begin
        case (r_state)
          c_IDLE: begin
            r_cnt <= '0;
            if (w_start_edge) begin
              r_state      <= c_RUN;
              r_band_lat   <= w_band_sel;
              r_period_lat <= w_period_sel;
            end
          end
          c_RUN: begin
            if (!SC_SPEEDSCHED_PAUSE_InLow) begin
              r_state <= c_PAUSE;
            end else if (w_term) begin
              // Band/period are only re-sampled here so a running period is never altered.
              r_load       <= 1'b1;
              r_cnt        <= '0;
              r_loadcnt    <= r_loadcnt + LOADCNT_WIDTH'(1);
              r_band_lat   <= w_band_sel;
              r_period_lat <= w_period_sel;
              r_bandchg    <= (w_band_sel != r_band_lat);
            end else begin
              r_cnt <= r_cnt + TIMER_WIDTH'(1);
            end
          end
          c_PAUSE: begin
            if (SC_SPEEDSCHED_PAUSE_InLow) r_state <= c_RUN;
          end
          default: r_state <= c_IDLE;
        endcase
      end
    end
  end

  assign SC_SPEEDSCHED_LOAD_Out      = r_load;
  assign SC_SPEEDSCHED_BAND_Out      = r_band_lat;
  assign SC_SPEEDSCHED_BANDCHG_Out   = r_bandchg;
  assign SC_SPEEDSCHED_STATE_Out     = r_state;
  assign SC_SPEEDSCHED_LOADCOUNT_Out = r_loadcnt;

endmodule
`default_nettype wire
